// File: rtl/router_pkg.sv
// Shared types and constants for the data bus router.
// Holds the FSM state encoding and the default target segment map.
package router_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        ERR   = 3'd4
    } state_e;

    // Channel i decodes addr[31:28] against nibble [4i+3:4i]
    localparam logic [15:0] TGT_SEG_DEF = {4'hF, 4'hC, 4'h8, 4'h0};

endpackage

// File: rtl/bus_timeout_ctr.sv
// Wait-state counter for the router; only built with ROUTER_TIMEOUT_EN.
// expired_o flags the wait cycle in which the count reaches TIMEOUT_CYC.
`ifdef ROUTER_TIMEOUT_EN
module bus_timeout_ctr #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired_o = enable_i && (cnt_q == CW'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/data_bus_router.sv
// Single-outstanding core-to-target bus router with address-segment decode.
// Define ROUTER_TIMEOUT_EN to abort stalled target accesses with an error.
module data_bus_router
    import router_pkg::*;
#(
    parameter int                 XLEN        = 64,
    parameter int                 N_TGT       = 4,
    parameter logic [N_TGT*4-1:0] TGT_SEG     = TGT_SEG_DEF,
    parameter int                 TIMEOUT_CYC = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  p_strobe_i,
    input  logic [XLEN-1:0]       p_addr_i,
    input  logic                  p_rw_i,
    input  logic [XLEN/8-1:0]     p_byte_enable_i,
    input  logic [XLEN-1:0]       p_data_i,
    output logic                  p_ready_o,
    output logic [XLEN-1:0]       p_data_o,
    output logic                  p_err_o,
    output logic                  busy_o,
    output logic [N_TGT-1:0]      t_strobe_o,
    output logic [XLEN-1:0]       t_addr_o,
    output logic                  t_rw_o,
    output logic [XLEN/8-1:0]     t_byte_enable_o,
    output logic [XLEN-1:0]       t_data_o,
    input  logic [N_TGT-1:0]      t_ready_i,
    input  logic [N_TGT*XLEN-1:0] t_data_i
);

    localparam int IDX_W = (N_TGT > 1) ? $clog2(N_TGT) : 1;

    state_e              state_q;
    logic [XLEN-1:0]     addr_q;
    logic                rw_q;
    logic [XLEN/8-1:0]   be_q;
    logic [XLEN-1:0]     wdata_q;
    logic [IDX_W-1:0]    idx_q;
    logic [N_TGT-1:0]    tstb_q;
    logic [XLEN-1:0]     rdata_q;
    logic                prdy_q;
    logic                perr_q;
    logic [XLEN-1:0]     pdata_q;

    logic                hit;
    logic [IDX_W-1:0]    hit_idx;
    logic                sel_rdy;
    logic [XLEN-1:0]     sel_data;
    logic                to_exp;

    // Descending scan so the lowest matching channel is the last writer
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = N_TGT - 1; i >= 0; i--) begin
            if (p_addr_i[31:28] == TGT_SEG[4*i +: 4]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign sel_rdy  = t_ready_i[idx_q];
    assign sel_data = t_data_i[XLEN*idx_q +: XLEN];

`ifdef ROUTER_TIMEOUT_EN
    bus_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (state_q == ISSUE),
        .enable_i  (state_q == WAIT),
        .expired_o (to_exp)
    );
`else
    assign to_exp = 1'b0;
`endif

    // Response outputs are loaded while leaving RESP/ERR
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            idx_q   <= '0;
            tstb_q  <= '0;
            rdata_q <= '0;
            prdy_q  <= 1'b0;
            perr_q  <= 1'b0;
            pdata_q <= '0;
        end else begin
            tstb_q  <= '0;
            prdy_q  <= 1'b0;
            perr_q  <= 1'b0;
            pdata_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (p_strobe_i) begin
                        addr_q  <= p_addr_i;
                        rw_q    <= p_rw_i;
                        be_q    <= p_byte_enable_i;
                        wdata_q <= p_data_i;
                        idx_q   <= hit_idx;
                        if (hit) begin
                            tstb_q  <= N_TGT'(1) << hit_idx;
                            state_q <= ISSUE;
                        end else begin
                            state_q <= ERR;
                        end
                    end
                end
                ISSUE: begin
                    if (sel_rdy) begin
                        rdata_q <= sel_data;
                        state_q <= RESP;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (sel_rdy) begin
                        rdata_q <= sel_data;
                        state_q <= RESP;
                    end else if (to_exp) begin
                        state_q <= ERR;
                    end
                end
                RESP: begin
                    prdy_q  <= 1'b1;
                    pdata_q <= rdata_q;
                    state_q <= IDLE;
                end
                ERR: begin
                    prdy_q  <= 1'b1;
                    perr_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o          = (state_q != IDLE);
    assign p_ready_o       = prdy_q;
    assign p_err_o         = perr_q;
    assign p_data_o        = pdata_q;
    assign t_strobe_o      = tstb_q;
    assign t_addr_o        = addr_q;
    assign t_rw_o          = rw_q;
    assign t_byte_enable_o = be_q;
    assign t_data_o        = wdata_q;

endmodule

// File: tb/tb_data_bus_router.sv
// Directed self-checking bench for data_bus_router.
// Channel 3 shares segment 8 with channel 1 so decode priority is visible.
module tb_data_bus_router;

    localparam int XLEN  = 64;
    localparam int N_TGT = 4;
    localparam int TOC   = 8;

    logic                  clk_i = 1'b0;
    logic                  rst_ni = 1'b1;
    logic                  p_strobe_i = 1'b0;
    logic [XLEN-1:0]       p_addr_i = '0;
    logic                  p_rw_i = 1'b0;
    logic [XLEN/8-1:0]     p_byte_enable_i = '0;
    logic [XLEN-1:0]       p_data_i = '0;
    logic                  p_ready_o;
    logic [XLEN-1:0]       p_data_o;
    logic                  p_err_o;
    logic                  busy_o;
    logic [N_TGT-1:0]      t_strobe_o;
    logic [XLEN-1:0]       t_addr_o;
    logic                  t_rw_o;
    logic [XLEN/8-1:0]     t_byte_enable_o;
    logic [XLEN-1:0]       t_data_o;
    logic [N_TGT-1:0]      t_ready_i = '0;
    logic [N_TGT*XLEN-1:0] t_data_i = '0;

    int n_run  = 0;
    int n_fail = 0;

    data_bus_router #(
        .XLEN        (XLEN),
        .N_TGT       (N_TGT),
        .TGT_SEG     (16'h8C80),
        .TIMEOUT_CYC (TOC)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .p_strobe_i      (p_strobe_i),
        .p_addr_i        (p_addr_i),
        .p_rw_i          (p_rw_i),
        .p_byte_enable_i (p_byte_enable_i),
        .p_data_i        (p_data_i),
        .p_ready_o       (p_ready_o),
        .p_data_o        (p_data_o),
        .p_err_o         (p_err_o),
        .busy_o          (busy_o),
        .t_strobe_o      (t_strobe_o),
        .t_addr_o        (t_addr_o),
        .t_rw_o          (t_rw_o),
        .t_byte_enable_o (t_byte_enable_o),
        .t_data_o        (t_data_o),
        .t_ready_i       (t_ready_i),
        .t_data_i        (t_data_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Presents a one-cycle request; returns one cycle later (ISSUE/ERR cycle)
    task automatic issue(input logic [XLEN-1:0] a, input logic rw,
                         input logic [7:0] be, input logic [XLEN-1:0] d);
        p_strobe_i      = 1'b1;
        p_addr_i        = a;
        p_rw_i          = rw;
        p_byte_enable_i = be;
        p_data_i        = d;
        step();
        p_strobe_i      = 1'b0;
        p_addr_i        = 64'hFFFF_0000_5555_AAAA;
        p_rw_i          = ~rw;
        p_byte_enable_i = ~be;
        p_data_i        = ~d;
    endtask

    task automatic test_reset();
        #2 rst_ni = 1'b0;
        #1;
        n_run++;
        if ({p_ready_o, p_err_o, busy_o, t_strobe_o, p_data_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b/%b/%b/%b/%h want 0",
                     p_ready_o, p_err_o, busy_o, t_strobe_o, p_data_o);
        end
        n_run++;
        if ({t_addr_o, t_rw_o, t_byte_enable_o, t_data_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_latch: got %h/%b/%h/%h want 0",
                     t_addr_o, t_rw_o, t_byte_enable_o, t_data_o);
        end
        step();
        step();
        rst_ni = 1'b1;
        step();
        n_run++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy got %b want 0", busy_o);
        end
    endtask

    task automatic test_read();
        issue(64'hC000_0010, 1'b0, 8'h00, 64'h0);
        n_run++;
        if ({t_strobe_o, busy_o} !== {4'b0100, 1'b1}) begin
            n_fail++;
            $display("FAIL rd_issue: strobe/busy got %b/%b want 0100/1",
                     t_strobe_o, busy_o);
        end
        step();
        n_run++;
        if ({t_strobe_o, p_ready_o} !== 5'b0) begin
            n_fail++;
            $display("FAIL rd_strobe_once: strobe/rdy got %b/%b want 0000/0",
                     t_strobe_o, p_ready_o);
        end
        t_ready_i = 4'b1011;
        t_data_i  = {64'h3333, 64'h0, 64'h1111, 64'h5A5A};
        step();
        step();
        n_run++;
        if ({p_ready_o, busy_o} !== 2'b01) begin
            n_fail++;
            $display("FAIL rd_other_rdy: rdy/busy got %b/%b want 0/1",
                     p_ready_o, busy_o);
        end
        step();
        t_ready_i = 4'b1111;
        t_data_i  = {64'h3333, 64'hDEAD_BEEF, 64'h1111, 64'h5A5A};
        step();
        t_ready_i = 4'b0000;
        t_data_i  = '0;
        n_run++;
        if ({p_ready_o, busy_o} !== 2'b01) begin
            n_fail++;
            $display("FAIL rd_resp_state: rdy/busy got %b/%b want 0/1",
                     p_ready_o, busy_o);
        end
        step();
        n_run++;
        if ({p_ready_o, p_err_o, p_data_o} !== {1'b1, 1'b0, 64'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL rd_resp: rdy/err/data got %b/%b/%h want 1/0/deadbeef",
                     p_ready_o, p_err_o, p_data_o);
        end
        step();
        n_run++;
        if ({p_ready_o, p_err_o, p_data_o} !== '0) begin
            n_fail++;
            $display("FAIL rd_after: rdy/err/data got %b/%b/%h want 0",
                     p_ready_o, p_err_o, p_data_o);
        end
    endtask

    task automatic test_write();
        issue(64'h8000_0008, 1'b1, 8'h0F, 64'h1234);
        n_run++;
        if (t_strobe_o !== 4'b0010) begin
            n_fail++;
            $display("FAIL wr_priority: strobe got %b want 0010", t_strobe_o);
        end
        for (int k = 1; k <= 4; k++) begin
            n_run++;
            if ({t_addr_o, t_rw_o, t_byte_enable_o, t_data_o} !==
                {64'h8000_0008, 1'b1, 8'h0F, 64'h1234}) begin
                n_fail++;
                $display("FAIL wr_latch_%0d: got %h/%b/%h/%h want 80000008/1/0f/1234",
                         k, t_addr_o, t_rw_o, t_byte_enable_o, t_data_o);
            end
            t_ready_i = (k == 3) ? 4'b1010 : 4'b0000;
            step();
        end
        t_ready_i = 4'b0000;
        n_run++;
        if ({p_ready_o, p_err_o, p_data_o} !== {1'b1, 1'b0, 64'h0}) begin
            n_fail++;
            $display("FAIL wr_resp: rdy/err/data got %b/%b/%h want 1/0/0",
                     p_ready_o, p_err_o, p_data_o);
        end
        step();
    endtask

    task automatic test_unmapped();
        logic [XLEN-1:0] addrs [2];
        addrs[0] = 64'h5000_0000;
        addrs[1] = 64'hF000_0000;
        for (int j = 0; j < 2; j++) begin
            issue(addrs[j], 1'b0, 8'h00, 64'h0);
            n_run++;
            if ({t_strobe_o, p_ready_o, busy_o} !== 6'b000001) begin
                n_fail++;
                $display("FAIL um%0d_t1: strobe/rdy/busy got %b/%b/%b want 0000/0/1",
                         j, t_strobe_o, p_ready_o, busy_o);
            end
            step();
            n_run++;
            if ({p_ready_o, p_err_o, p_data_o, t_strobe_o} !=
                {1'b1, 1'b1, 64'h0, 4'b0}) begin
                n_fail++;
                $display("FAIL um%0d_resp: rdy/err/data got %b/%b/%h want 1/1/0",
                         j, p_ready_o, p_err_o, p_data_o);
            end
            step();
            n_run++;
            if ({p_ready_o, p_err_o, busy_o} !== 3'b000) begin
                n_fail++;
                $display("FAIL um%0d_after: rdy/err/busy got %b/%b/%b want 0",
                         j, p_ready_o, p_err_o, busy_o);
            end
        end
    endtask

    task automatic test_min_latency();
        issue(64'h0000_0100, 1'b0, 8'h00, 64'h0);
        t_ready_i = 4'b0001;
        t_data_i  = {192'h0, 64'hA5A5};
        n_run++;
        if (t_strobe_o !== 4'b0001) begin
            n_fail++;
            $display("FAIL ml_strobe: got %b want 0001", t_strobe_o);
        end
        step();
        t_ready_i = 4'b0000;
        t_data_i  = '0;
        n_run++;
        if ({p_ready_o, busy_o} !== 2'b01) begin
            n_fail++;
            $display("FAIL ml_t2: rdy/busy got %b/%b want 0/1", p_ready_o, busy_o);
        end
        step();
        n_run++;
        if ({p_ready_o, p_err_o, p_data_o} !== {1'b1, 1'b0, 64'hA5A5}) begin
            n_fail++;
            $display("FAIL ml_t3: rdy/err/data got %b/%b/%h want 1/0/a5a5",
                     p_ready_o, p_err_o, p_data_o);
        end
        step();
    endtask

    task automatic test_busy_ignore();
        int pulses;
        issue(64'hC000_0040, 1'b0, 8'h00, 64'h0);
        step();
        step();
        p_strobe_i      = 1'b1;
        p_addr_i        = 64'h0;
        p_rw_i          = 1'b1;
        p_byte_enable_i = 8'hFF;
        p_data_i        = 64'hFFFF;
        step();
        p_strobe_i = 1'b0;
        n_run++;
        if ({t_addr_o, t_rw_o, t_data_o, t_strobe_o} !==
            {64'hC000_0040, 1'b0, 64'h0, 4'b0}) begin
            n_fail++;
            $display("FAIL bi_latch: addr/rw/data/strobe got %h/%b/%h/%b",
                     t_addr_o, t_rw_o, t_data_o, t_strobe_o);
        end
        t_ready_i = 4'b0100;
        t_data_i  = {64'h0, 64'h77, 128'h0};
        step();
        t_ready_i = 4'b0000;
        t_data_i  = '0;
        step();
        n_run++;
        if ({p_ready_o, p_err_o, p_data_o} !== {1'b1, 1'b0, 64'h77}) begin
            n_fail++;
            $display("FAIL bi_resp: rdy/err/data got %b/%b/%h want 1/0/77",
                     p_ready_o, p_err_o, p_data_o);
        end
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (p_ready_o || t_strobe_o != 4'b0) pulses++;
        end
        n_run++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL bi_single: extra activity got %0d want 0", pulses);
        end
    endtask

    task automatic test_back_to_back();
        issue(64'h0000_0200, 1'b0, 8'h00, 64'h0);
        t_ready_i = 4'b0001;
        t_data_i  = {192'h0, 64'h1};
        step();
        t_ready_i = 4'b0000;
        step();
        n_run++;
        if ({p_ready_o, p_data_o, busy_o} !== {1'b1, 64'h1, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_a: rdy/data/busy got %b/%h/%b want 1/1/0",
                     p_ready_o, p_data_o, busy_o);
        end
        issue(64'hC000_0300, 1'b0, 8'h00, 64'h0);
        n_run++;
        if ({t_strobe_o, t_addr_o} !== {4'b0100, 64'hC000_0300}) begin
            n_fail++;
            $display("FAIL b2b_b_issue: strobe/addr got %b/%h want 0100/c0000300",
                     t_strobe_o, t_addr_o);
        end
        t_ready_i = 4'b0100;
        t_data_i  = {64'h0, 64'h2, 128'h0};
        step();
        t_ready_i = 4'b0000;
        t_data_i  = '0;
        step();
        n_run++;
        if ({p_ready_o, p_err_o, p_data_o} !== {1'b1, 1'b0, 64'h2}) begin
            n_fail++;
            $display("FAIL b2b_b_resp: rdy/err/data got %b/%b/%h want 1/0/2",
                     p_ready_o, p_err_o, p_data_o);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int pulses;
        issue(64'h0000_0400, 1'b1, 8'h3C, 64'h99);
        step();
        step();
        rst_ni = 1'b0;
        #1;
        n_run++;
        if ({busy_o, t_strobe_o, p_ready_o, p_err_o, p_data_o} !== '0) begin
            n_fail++;
            $display("FAIL rm_ctrl: busy/strobe/rdy/err/data got %b/%b/%b/%b/%h want 0",
                     busy_o, t_strobe_o, p_ready_o, p_err_o, p_data_o);
        end
        n_run++;
        if ({t_addr_o, t_rw_o, t_byte_enable_o, t_data_o} !== '0) begin
            n_fail++;
            $display("FAIL rm_latch: got %h/%b/%h/%h want 0",
                     t_addr_o, t_rw_o, t_byte_enable_o, t_data_o);
        end
        t_ready_i = 4'b1111;
        t_data_i  = {4{64'hBAD}};
        step();
        rst_ni = 1'b1;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (p_ready_o || busy_o) pulses++;
        end
        t_ready_i = 4'b0000;
        t_data_i  = '0;
        n_run++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL rm_no_resp: activity after release got %0d want 0", pulses);
        end
    endtask

`ifdef ROUTER_TIMEOUT_EN
    task automatic test_timeout();
        int early;
        issue(64'h0000_0500, 1'b0, 8'h00, 64'h0);
        early = 0;
        for (int k = 2; k <= 10; k++) begin
            step();
            if (p_ready_o) early++;
        end
        n_run++;
        if (early !== 0) begin
            n_fail++;
            $display("FAIL to_early: p_ready cycles got %0d want 0", early);
        end
        step();
        n_run++;
        if ({p_ready_o, p_err_o, p_data_o} !== {1'b1, 1'b1, 64'h0}) begin
            n_fail++;
            $display("FAIL to_expire: rdy/err/data got %b/%b/%h want 1/1/0",
                     p_ready_o, p_err_o, p_data_o);
        end
        step();
        issue(64'h0000_0500, 1'b0, 8'h00, 64'h0);
        for (int k = 2; k <= 9; k++) step();
        t_ready_i = 4'b0001;
        t_data_i  = {192'h0, 64'h9};
        step();
        t_ready_i = 4'b0000;
        t_data_i  = '0;
        step();
        n_run++;
        if ({p_ready_o, p_err_o, p_data_o} !== {1'b1, 1'b0, 64'h9}) begin
            n_fail++;
            $display("FAIL to_ready_wins: rdy/err/data got %b/%b/%h want 1/0/9",
                     p_ready_o, p_err_o, p_data_o);
        end
        step();
    endtask
`else
    task automatic test_no_timeout();
        int early;
        issue(64'h0000_0600, 1'b0, 8'h00, 64'h0);
        early = 0;
        for (int k = 0; k < 3 * TOC; k++) begin
            step();
            if (p_ready_o || !busy_o) early++;
        end
        n_run++;
        if (early !== 0) begin
            n_fail++;
            $display("FAIL nt_wait: early exit cycles got %0d want 0", early);
        end
        t_ready_i = 4'b0001;
        t_data_i  = {192'h0, 64'h6};
        step();
        t_ready_i = 4'b0000;
        t_data_i  = '0;
        step();
        n_run++;
        if ({p_ready_o, p_err_o, p_data_o} !== {1'b1, 1'b0, 64'h6}) begin
            n_fail++;
            $display("FAIL nt_resp: rdy/err/data got %b/%b/%h want 1/0/6",
                     p_ready_o, p_err_o, p_data_o);
        end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_write();
        test_unmapped();
        test_min_latency();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
`ifdef ROUTER_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/data_bus_router.md
DATA_BUS_ROUTER -- requirements
Module: data_bus_router

Interface
REQ-001 Parameters SHALL be:
- XLEN, default 64, data/address width.
- N_TGT, default 4, target channel count, range 1..8.
- TGT_SEG, default {4'hF,4'hC,4'h8,4'h0}, N_TGT*4-bit map of addr[31:28] nibble per target; channel i uses bits [4i+3:4i].
- TIMEOUT_CYC, default 255, maximum cycles to wait for target ready, minimum 2.
REQ-002 Ports SHALL be, in this order:
- clk_i  in  1  sole clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- p_strobe_i  in  1  core request pulse.
- p_addr_i  in  XLEN  request address.
- p_rw_i  in  1  1=write.
- p_byte_enable_i  in  XLEN/8  write byte lanes.
- p_data_i  in  XLEN  write data.
- p_ready_o  out  1  one-cycle completion pulse.
- p_data_o  out  XLEN  read data, valid with p_ready_o.
- p_err_o  out  1  error flag, valid with p_ready_o.
- busy_o  out  1  request in flight.
- t_strobe_o  out  N_TGT  per-target request pulse.
- t_addr_o  out  XLEN  shared latched address.
- t_rw_o  out  1  shared latched rw.
- t_byte_enable_o  out  XLEN/8  shared latched byte enables.
- t_data_o  out  XLEN  shared latched write data.
- t_ready_i  in  N_TGT  per-target done.
- t_data_i  in  N_TGT*XLEN  per-target read data, channel i at [XLEN*i +: XLEN].

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP, ERR.
REQ-004 In IDLE, p_strobe_i SHALL register addr, rw, byte_enable, data and the decoded target index; lowest matching index wins.
- Match found: next state ISSUE.
- No match: next state ERR.
REQ-005 ISSUE SHALL last one cycle, assert exactly one bit t_strobe_o[idx], then go to WAIT.
REQ-006 In WAIT, t_ready_i[idx]=1 SHALL capture t_data_i of idx into a response register and go to RESP; t_ready_i bits of other channels SHALL be ignored.
REQ-007 RESP and ERR SHALL each last one cycle with p_ready_o=1, then return to IDLE.
- RESP: p_err_o=0, p_data_o=captured data.
- ERR: p_err_o=1, p_data_o=0.
REQ-008 Minimum latency SHALL be 3 cycles: strobe at T, t_strobe at T+1, t_ready at T+1, p_ready at T+3.
REQ-009 busy_o SHALL be 1 in every state except IDLE.
REQ-010 p_strobe_i while busy_o=1 SHALL be ignored, with no state or data change.
REQ-011 t_ready_i[idx] arriving in the ISSUE cycle SHALL be honoured as if it arrived in WAIT.
REQ-012 t_addr_o, t_rw_o, t_byte_enable_o and t_data_o SHALL hold the latched values stable from ISSUE through RESP.
REQ-013 p_ready_o and p_err_o SHALL be 0 outside RESP and ERR, and p_data_o SHALL be 0 outside RESP.

Reset
REQ-014 rst_ni low SHALL immediately force the following, including mid-transaction, with no pending response delivered after release:
- state=IDLE.
- t_strobe_o=0, p_ready_o=0, p_err_o=0, busy_o=0.
- p_data_o=0, all latched registers=0, timeout counter=0.

Configuration
REQ-015 With macro ROUTER_TIMEOUT_EN defined:
- A counter SHALL clear on entry to WAIT and increment each WAIT cycle.
- When it reaches TIMEOUT_CYC without t_ready_i[idx], the FSM SHALL go to ERR.
- t_ready_i[idx] in the same cycle as expiry SHALL win, going to RESP.
REQ-016 Without ROUTER_TIMEOUT_EN, the counter SHALL be absent, WAIT SHALL wait indefinitely, and ERR SHALL be reached only on an unmapped address.

Structure
REQ-017 Package router_pkg SHALL hold the state enum, state encoding width, and the default TGT_SEG constant.
REQ-018 The timeout counter SHALL be sub-module bus_timeout_ctr, with inputs clear/enable, output expired, and parameter TIMEOUT_CYC; it SHALL be instantiated only under ROUTER_TIMEOUT_EN.

Verification
REQ-019 Read to 0xC000_0010, target 2 ready after 4 cycles with data 0xDEAD_BEEF -> t_strobe_o=4'b0100 for one cycle; p_ready_o at T+7 with p_data_o=0xDEAD_BEEF and p_err_o=0.
REQ-020 Write to 0x8000_0008 with be=8'h0F, data 0x1234 -> t_addr_o, t_byte_enable_o and t_data_o stable until ready; p_ready_o=1 with p_err_o=0.
REQ-021 Access to 0x5000_0000 (unmapped) -> no t_strobe_o; p_ready_o=1 with p_err_o=1 at T+2.
REQ-022 With ROUTER_TIMEOUT_EN and TIMEOUT_CYC=8, target never ready -> p_err_o=1 exactly 8 cycles after entering WAIT; second run with ready at cycle 8 -> p_err_o=0.
REQ-023 Second p_strobe_i during WAIT -> ignored, single p_ready_o; rst_ni pulsed low in WAIT -> all outputs 0 immediately, and no p_ready_o after release.
